i2s_rx_source: RTL and testbench

Mono I2S receiver that deserializes the left channel of an external ADC serial stream. It delivers fixed-point samples over a valid/ready producer interface, the sending side of the handshake the `tuner` consumes on `audio_i`/`valid_i`/`ready_o`. It sits between the board ADC pins and `tuner`. It absorbs consumer stalls in a small FIFO and flags lost samples.

---
 rtl/i2s_rx_source.sv | 96 +++++++++
 tb/tb_i2s_rx_source.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_source.sv
// i2s_rx_source: mono I2S left-channel receiver with a small output FIFO and sticky overflow flag.
module i2s_rx_source #(
   parameter int int_out_p     = 1,
   parameter int frac_out_p    = 11,
   parameter int sample_bits_p = 24,
   parameter int fifo_depth_p  = 4
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic                                  bclk_i,
   input  logic                                  lrclk_i,
   input  logic                                  sdata_i,
   output logic signed [int_out_p-1:-frac_out_p] audio_o,
   output logic                                  valid_o,
   input  logic                                  ready_i,
   output logic                                  overflow_o
);
   localparam int w  = int_out_p + frac_out_p;
   localparam int aw = $clog2(fifo_depth_p);
   localparam int cw = $clog2(sample_bits_p);
   localparam logic [cw-1:0] last = cw'(sample_bits_p - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

   logic [1:0] bclk_q, lrclk_q, sdata_q;
   logic bclk_s, lrclk_s, sdata_s, bclk_d, bclk_rise, lr_prev;
   state_t state;
   logic [cw-1:0] bitcnt;
   logic [sample_bits_p-1:0] shreg;
   logic [w-1:0] mem [fifo_depth_p];
   logic [aw:0] wr, rd;
   logic full, push, pop;

   assign bclk_s    = bclk_q[1];
   assign lrclk_s   = lrclk_q[1];
   assign sdata_s   = sdata_q[1];
   assign bclk_rise = bclk_s & ~bclk_d;
   assign push      = state == PUSH;
   assign valid_o   = wr != rd;
   assign pop       = valid_o & ready_i;
   assign full      = (wr[aw] != rd[aw]) && (wr[aw-1:0] == rd[aw-1:0]);
   assign audio_o   = mem[rd[aw-1:0]];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         bclk_q  <= '0;
         lrclk_q <= '0;
         sdata_q <= '0;
         bclk_d  <= 1'b0;
         lr_prev <= 1'b0;
         state   <= IDLE;
         bitcnt  <= '0;
         shreg   <= '0;
      end else begin
         bclk_q  <= {bclk_q[0], bclk_i};
         lrclk_q <= {lrclk_q[0], lrclk_i};
         sdata_q <= {sdata_q[0], sdata_i};
         bclk_d  <= bclk_s;
         if (bclk_rise) lr_prev <= lrclk_s;
         case (state)
            IDLE: if (bclk_rise && !lrclk_s && lr_prev) begin
               state  <= SHIFT;
               bitcnt <= '0;
               shreg  <= '0;
            end
            SHIFT: if (bclk_rise) begin
               // In I2S the left LSB coincides with lrclk going high, so only earlier bits abort
               if (lrclk_s && bitcnt != last) state <= IDLE;
               else begin
                  shreg  <= {shreg[sample_bits_p-2:0], sdata_s};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == last) state <= PUSH;
               end
            end
            PUSH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < fifo_depth_p; i++) mem[i] <= '0;
         wr         <= '0;
         rd         <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push && (!full || pop)) begin
            mem[wr[aw-1:0]] <= shreg[sample_bits_p-1 -: w];
            wr              <= wr + 1'b1;
         end
         if (push && full && !pop) overflow_o <= 1'b1;
         if (pop) rd <= rd + 1'b1;
      end
   end
endmodule

// File: tb/tb_i2s_rx_source.sv
// tb_i2s_rx_source: directed vector bench for i2s_rx_source with hand-built I2S frames.
module tb_i2s_rx_source;
   logic clk = 1'b0, reset_n = 1'b0, bclk = 1'b0, lrclk = 1'b1, sdata = 1'b0, ready = 1'b1;
   logic signed [0:-11] audio;
   logic valid, overflow;
   int n_chk = 0, n_err = 0;
   logic [11:0] popped [$];

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [11:0] exp;
   } vec_t;
   vec_t vecs [7];

   i2s_rx_source dut (
      .clk_i(clk), .reset_n_i(reset_n), .bclk_i(bclk), .lrclk_i(lrclk), .sdata_i(sdata),
      .audio_o(audio), .valid_o(valid), .ready_i(ready), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (reset_n && valid && ready) popped.push_back(audio);

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // mode 1: check valid latency around this bit, mode 2: pulse ready across the push edge
   task automatic bit_out(input logic lr, input logic d, input int mode);
      lrclk = lr;
      sdata = d;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         if (mode == 1 && e >= 3) chk("latency_valid", {31'b0, valid}, {31'b0, e == 4});
         if (mode == 2 && e == 3) ready = 1'b1;
         if (mode == 2 && e == 4) ready = 1'b0;
      end
      bclk = 1'b0;
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int mode);
      for (int k = 0; k < 48; k++) begin
         logic dd;
         dd = (k == 0) ? 1'b0 : (k <= 24) ? l[24-k] : r[48-k];
         bit_out(k >= 24, dd, (k == 24) ? mode : 0);
      end
   endtask

   task automatic preamble();
      repeat (4) bit_out(1'b1, 1'b0, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_valid", {31'b0, valid}, 0);
      chk("rst_audio", {20'b0, audio}, 0);
      chk("rst_ovf", {31'b0, overflow}, 0);
      for (int i = 0; i < 5; i++) begin
         bclk  = i[0];
         lrclk = ~i[0];
         sdata = 1'b1;
         @(negedge clk);
         chk("rst_valid", {31'b0, valid}, 0);
         chk("rst_audio", {20'b0, audio}, 0);
         chk("rst_ovf", {31'b0, overflow}, 0);
      end
      reset_n = 1'b1;
      bclk    = 1'b0;
      lrclk   = 1'b1;
      sdata   = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{24'h7FF123, 24'hABCDEF, 12'h7FF};
      vecs[1] = '{24'h800000, 24'h123456, 12'h800};
      vecs[2] = '{24'hFFFFFF, 24'h000000, 12'hFFF};
      vecs[3] = '{24'h000FFF, 24'hFFFFFF, 12'h000};
      vecs[4] = '{24'h400000, 24'h555555, 12'h400};
      vecs[5] = '{24'h123456, 24'h000001, 12'h123};
      vecs[6] = '{24'hABCDEF, 24'h7FF123, 12'hABC};

      @(negedge clk);
      do_reset();
      // left-channel bits right after release must not start a word
      repeat (5) bit_out(1'b0, 1'b1, 0);
      preamble();
      chk("no_early_push", popped.size(), 0);
      chk("no_early_valid", {31'b0, valid}, 0);

      for (int i = 0; i < 7; i++) begin
         popped.delete();
         send_frame(vecs[i].l, vecs[i].r, (i == 0) ? 1 : 0);
         chk("vec_count", popped.size(), 1);
         chk("vec_value", {20'b0, (popped.size() > 0) ? popped[0] : 12'hxxx}, {20'b0, vecs[i].exp});
         chk("vec_valid_low", {31'b0, valid}, 0);
         chk("vec_ovf", {31'b0, overflow}, 0);
      end

      ready = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         send_frame({n[11:0], 12'h000}, 24'h0F0F0F, 0);
         chk("bp_valid", {31'b0, valid}, 1);
         chk("bp_head", {20'b0, audio}, 1);
         chk("bp_ovf", {31'b0, overflow}, {31'b0, n == 5});
      end
      popped.delete();
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_pop_valid", {31'b0, valid}, 1);
         chk("bp_pop_value", {20'b0, audio}, i + 1);
         @(negedge clk);
      end
      chk("bp_empty", {31'b0, valid}, 0);
      chk("bp_ovf_sticky", {31'b0, overflow}, 1);
      chk("bp_pop_count", popped.size(), 4);

      do_reset();
      chk("ovf_cleared", {31'b0, overflow}, 0);
      preamble();
      ready = 1'b0;
      popped.delete();
      for (int n = 0; n < 4; n++) send_frame({12'h010 + 12'(n), 12'h000}, 24'h000000, 0);
      chk("full_valid", {31'b0, valid}, 1);
      send_frame(24'h014000, 24'h000000, 2);
      chk("full_pop_ovf", {31'b0, overflow}, 0);
      ready = 1'b1;
      repeat (8) @(negedge clk);
      chk("full_pop_count", popped.size(), 5);
      for (int i = 0; i < 5; i++)
         chk("full_pop_order", {20'b0, (popped.size() > i) ? popped[i] : 12'hxxx}, 32'h10 + i);
      chk("full_pop_ovf_end", {31'b0, overflow}, 0);

      do_reset();
      preamble();
      popped.delete();
      for (int k = 0; k < 11; k++) bit_out(1'b0, 1'b1, 0);
      repeat (24) bit_out(1'b1, 1'b0, 0);
      chk("short_no_push", popped.size(), 0);
      chk("short_valid", {31'b0, valid}, 0);

      ready = 1'b0;
      send_frame(24'h555000, 24'h000000, 0);
      chk("mid_pre_valid", {31'b0, valid}, 1);
      bit_out(1'b0, 1'b0, 0);
      repeat (8) bit_out(1'b0, 1'b1, 0);
      do_reset();
      ready = 1'b1;
      popped.delete();
      preamble();
      send_frame(24'h400000, 24'h000000, 0);
      chk("mid_after_count", popped.size(), 1);
      chk("mid_after_value", {20'b0, (popped.size() > 0) ? popped[0] : 12'hxxx}, 32'h400);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
